// File: rtl/draw_pkg.sv
// Shared types and entity record layout for the draw scheduler and the sprite drawers.
package draw_pkg;

  localparam int ENTITY_SIZE = 34;
  localparam int VALID_BIT   = 33;

  // Entity record field slices; bit 33 is the plot/valid flag.
  localparam int X_LSB      = 0;
  localparam int X_W        = 10;
  localparam int Y_LSB      = 10;
  localparam int Y_W        = 10;
  localparam int DIR_LSB    = 20;
  localparam int DIR_W      = 5;
  localparam int SPRITE_LSB = 25;
  localparam int SPRITE_W   = 8;
  localparam int VALID_LSB  = VALID_BIT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_WAIT,
    ST_NEXT_SLOT,
    ST_NEXT_CLASS,
    ST_DONE
  } state_e;

endpackage

// File: rtl/slot_walker.sv
// Class/slot position counters for the draw sweep, with per-class count clamp and end detection.
module slot_walker #(
  parameter int NUM_CLASSES = 3,
  parameter int SLOTS       = 16,
  parameter int CLS_W       = 2,
  parameter int SLOT_W      = 4,
  parameter int CNT_W       = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         slot_inc,
  input  logic                         class_inc,
  input  logic [NUM_CLASSES*CNT_W-1:0] class_count,
  output logic [CLS_W-1:0]             cls,
  output logic [SLOT_W-1:0]            slot,
  output logic                         slot_empty,
  output logic                         last_slot,
  output logic                         last_class
);
  import draw_pkg::*;

  logic [CLS_W-1:0]  cls_q, cls_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  cur_count;
  logic [CNT_W-1:0]  lim;

  // Loop-select avoids reading past the packed vector for unused cls codes.
  always_comb begin
    cur_count = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (cls_q == CLS_W'(c)) cur_count = class_count[c*CNT_W +: CNT_W];
    end
    lim = (cur_count > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : cur_count;
  end

  always_comb begin
    cls_d  = cls_q;
    slot_d = slot_q;
    if (clr) begin
      cls_d  = '0;
      slot_d = '0;
    end else if (class_inc) begin
      cls_d  = cls_q + CLS_W'(1);
      slot_d = '0;
    end else if (slot_inc) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cls_q  <= '0;
      slot_q <= '0;
    end else begin
      cls_q  <= cls_d;
      slot_q <= slot_d;
    end
  end

  assign cls        = cls_q;
  assign slot       = slot_q;
  assign slot_empty = (CNT_W'(slot_q) >= lim);
  assign last_slot  = (slot_q == SLOT_W'(SLOTS - 1));
  assign last_class = (cls_q == CLS_W'(NUM_CLASSES - 1));

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame entity walker: hands each valid entity to its class drawer over a start/done
// handshake, with erase mode, drawer timeout and busy/frame_done status.
module draw_scheduler #(
  parameter int ENTITY_SIZE = draw_pkg::ENTITY_SIZE,
  parameter int NUM_CLASSES = 3,
  parameter int SLOTS       = 16,
  parameter int VALID_BIT   = draw_pkg::VALID_BIT,
  parameter int TIMEOUT     = 4096
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      frame_start,
  input  logic                                      erase_in,
  input  logic [NUM_CLASSES*$clog2(SLOTS+1)-1:0]    class_count,
  input  logic [NUM_CLASSES*SLOTS*ENTITY_SIZE-1:0]  entity_table,
  input  logic [NUM_CLASSES-1:0]                    draw_done,
  output logic [ENTITY_SIZE-1:0]                    entity,
  output logic [NUM_CLASSES-1:0]                    class_sel,
  output logic [NUM_CLASSES-1:0]                    draw_start,
  output logic                                      erase,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      timeout_err
);
  import draw_pkg::*;

  localparam int CNT_W  = $clog2(SLOTS + 1);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                   state_q, state_d;
  logic [ENTITY_SIZE-1:0]   entity_q, entity_d;
  logic [NUM_CLASSES-1:0]   class_sel_q, class_sel_d;
  logic                     erase_q, erase_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0]         wait_cnt_q, wait_cnt_d;

  logic                     walk_clr, walk_slot_inc, walk_class_inc;
  logic [CLS_W-1:0]         cls;
  logic [SLOT_W-1:0]        slot;
  logic                     slot_empty, last_slot, last_class;

  logic [ENTITY_SIZE-1:0]   rec;
  logic [NUM_CLASSES-1:0]   cls_onehot;
  logic                     done_sel;

  slot_walker #(
    .NUM_CLASSES (NUM_CLASSES),
    .SLOTS       (SLOTS),
    .CLS_W       (CLS_W),
    .SLOT_W      (SLOT_W),
    .CNT_W       (CNT_W)
  ) u_walker (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (walk_clr),
    .slot_inc    (walk_slot_inc),
    .class_inc   (walk_class_inc),
    .class_count (class_count),
    .cls         (cls),
    .slot        (slot),
    .slot_empty  (slot_empty),
    .last_slot   (last_slot),
    .last_class  (last_class)
  );

  always_comb begin
    int unsigned idx;
    idx        = int'(cls) * SLOTS + int'(slot);
    rec        = entity_table[idx*ENTITY_SIZE +: ENTITY_SIZE];
    cls_onehot = NUM_CLASSES'(1) << cls;
  end

  // Only the selected drawer may end a wait; stray acks from other drawers are ignored.
  assign done_sel = |(draw_done & class_sel_q);

  always_comb begin
    state_d        = state_q;
    entity_d       = entity_q;
    class_sel_d    = class_sel_q;
    erase_d        = erase_q;
    timeout_err_d  = timeout_err_q;
    wait_cnt_d     = wait_cnt_q;
    walk_clr       = 1'b0;
    walk_slot_inc  = 1'b0;
    walk_class_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          erase_d  = erase_in;
          walk_clr = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (slot_empty) begin
          state_d = ST_NEXT_CLASS;
        end else if (!rec[VALID_BIT]) begin
          state_d = ST_NEXT_SLOT;
        end else begin
          entity_d    = rec;
          class_sel_d = cls_onehot;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_sel) begin
          state_d = ST_NEXT_SLOT;
        end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_NEXT_SLOT;
        end else begin
          wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end
      end
      ST_NEXT_SLOT: begin
        walk_slot_inc = 1'b1;
        state_d       = last_slot ? ST_NEXT_CLASS : ST_FETCH;
      end
      ST_NEXT_CLASS: begin
        walk_class_inc = 1'b1;
        if (last_class) begin
          class_sel_d = '0;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      entity_q      <= '0;
      class_sel_q   <= '0;
      erase_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      entity_q      <= entity_d;
      class_sel_q   <= class_sel_d;
      erase_q       <= erase_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign entity      = entity_q;
  assign class_sel   = class_sel_q;
  assign draw_start  = (state_q == ST_START) ? class_sel_q : '0;
  assign erase       = erase_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: draw order, skipping, clamp, timeout, erase latch and reset abort.
module tb_draw_scheduler;

  localparam int NC      = 3;
  localparam int SL      = 4;
  localparam int ES      = 34;
  localparam int CW      = 3;
  localparam int TMO     = 16;
  localparam int ACK_DLY = 5;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  frame_start;
  logic                  erase_in;
  logic [NC*CW-1:0]      class_count;
  logic [NC*SL*ES-1:0]   entity_table;
  logic [NC-1:0]         draw_done = '0;
  logic [ES-1:0]         entity;
  logic [NC-1:0]         class_sel;
  logic [NC-1:0]         draw_start;
  logic                  erase;
  logic                  busy;
  logic                  frame_done;
  logic                  timeout_err;

  draw_scheduler #(
    .ENTITY_SIZE (ES),
    .NUM_CLASSES (NC),
    .SLOTS       (SL),
    .VALID_BIT   (33),
    .TIMEOUT     (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .erase_in     (erase_in),
    .class_count  (class_count),
    .entity_table (entity_table),
    .draw_done    (draw_done),
    .entity       (entity),
    .class_sel    (class_sel),
    .draw_start   (draw_start),
    .erase        (erase),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         n_starts = 0;
  int         n_done   = 0;
  int         cyc_ctr  = 0;
  int         te_rise  = -1;
  logic       prev_te  = 1'b0;
  logic [NC-1:0] log_sel [64];
  logic [9:0]    log_x   [64];
  int            log_cyc [64];

  int ack_cnt  [NC] = '{default: 0};
  bit misroute [NC] = '{default: 1'b0};

  // Monitor: logs every draw_start cycle with the entity tag, frame_done pulses and timeout_err rise.
  always @(negedge clk) begin
    cyc_ctr++;
    if (draw_start != '0 && n_starts < 64) begin
      log_sel[n_starts] = draw_start;
      log_x[n_starts]   = entity[9:0];
      log_cyc[n_starts] = cyc_ctr;
      n_starts++;
    end
    if (frame_done) n_done++;
    if (timeout_err && !prev_te) te_rise = cyc_ctr;
    prev_te = timeout_err;
  end

  // Drawer model: acks ACK_DLY cycles after start; a misrouted class pulses the next drawer's bit instead.
  always @(negedge clk) begin
    draw_done = '0;
    for (int c = 0; c < NC; c++) begin
      if (ack_cnt[c] > 0) begin
        ack_cnt[c]--;
        if (ack_cnt[c] == 0) begin
          if (misroute[c]) draw_done[(c + 1) % NC] = 1'b1;
          else             draw_done[c] = 1'b1;
        end
      end
      if (draw_start[c]) ack_cnt[c] = ACK_DLY;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ent(input int c, input int s, input logic v);
    logic [9:0] tag;
    tag = 10'(c * 16 + s);
    entity_table[(c*SL + s)*ES +: ES] = {v, 23'd0, tag};
  endtask

  // Cycle numbering: the frame_start cycle is 1; cyc is the cycle in which frame_done is seen.
  task automatic run_frame(input int poke, input logic e, output int cyc,
                           output logic [NC-1:0] sel_at_done, output logic busy_at_done);
    erase_in    = e;
    frame_start = 1'b1;
    cyc         = 1;
    sel_at_done = 'x;
    busy_at_done = 1'bx;
    @(negedge clk);
    frame_start = 1'b0;
    while (cyc < 200) begin
      cyc++;
      frame_start = (cyc == poke);
      if (cyc == poke) erase_in = ~e;
      if (frame_done) begin
        sel_at_done  = class_sel;
        busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    int            cyc;
    int            base;
    int            d0;
    int            k;
    logic [NC-1:0] sel_d;
    logic          busy_d;

    reset_n      = 1'b0;
    frame_start  = 1'b0;
    erase_in     = 1'b0;
    class_count  = '0;
    entity_table = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",       busy,        1'b0);
    check("rst_frame_done", frame_done,  1'b0);
    check("rst_class_sel",  class_sel,   3'b000);
    check("rst_draw_start", draw_start,  3'b000);
    check("rst_erase",      erase,       1'b0);
    check("rst_timeout",    timeout_err, 1'b0);
    check("rst_entity",     entity,      34'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_start_busy", busy, 1'b0);

    // Counts {1,3,0}, all valid, normal acks.
    entity_table = '0;
    set_ent(0, 0, 1'b1);
    set_ent(1, 0, 1'b1);
    set_ent(1, 1, 1'b1);
    set_ent(1, 2, 1'b1);
    class_count = {3'd0, 3'd3, 3'd1};
    base = n_starts; d0 = n_done;
    run_frame(0, 1'b0, cyc, sel_d, busy_d);
    check("t1_latency",      cyc,    40);
    check("t1_sel_at_done",  sel_d,  3'b000);
    check("t1_busy_at_done", busy_d, 1'b1);
    check("t1_busy_after",   busy,   1'b0);
    repeat (2) @(negedge clk);
    check("t1_nstarts", n_starts - base, 4);
    check("t1_s0_sel", log_sel[base+0], 3'b001);
    check("t1_s0_x",   log_x[base+0],   10'h000);
    check("t1_s1_sel", log_sel[base+1], 3'b010);
    check("t1_s1_x",   log_x[base+1],   10'h010);
    check("t1_s2_x",   log_x[base+2],   10'h011);
    check("t1_s3_sel", log_sel[base+3], 3'b010);
    check("t1_s3_x",   log_x[base+3],   10'h012);
    check("t1_ndone",  n_done - d0,     1);

    // Class 1 count 4 with slots 1 and 3 invalid.
    entity_table = '0;
    set_ent(1, 0, 1'b1);
    set_ent(1, 1, 1'b0);
    set_ent(1, 2, 1'b1);
    set_ent(1, 3, 1'b0);
    class_count = {3'd0, 3'd4, 3'd0};
    base = n_starts;
    run_frame(0, 1'b0, cyc, sel_d, busy_d);
    check("t2_latency", cyc, 27);
    repeat (2) @(negedge clk);
    check("t2_nstarts", n_starts - base, 2);
    check("t2_s0_x", log_x[base+0], 10'h010);
    check("t2_s1_x", log_x[base+1], 10'h012);

    // Count above SLOTS is clamped.
    entity_table = '0;
    for (int s = 0; s < SL; s++) set_ent(0, s, 1'b1);
    class_count = {3'd0, 3'd0, 3'd7};
    base = n_starts;
    run_frame(0, 1'b0, cyc, sel_d, busy_d);
    check("clamp_latency", cyc, 39);
    repeat (2) @(negedge clk);
    check("clamp_nstarts", n_starts - base, 4);
    check("clamp_last_x",  log_x[base+3],   10'h003);

    // Drawer 0 never acks its own bit (pokes drawer 1's instead): timeout.
    entity_table = '0;
    set_ent(0, 0, 1'b1);
    class_count = {3'd0, 3'd0, 3'd1};
    misroute[0] = 1'b1;
    check("t3_te_before", timeout_err, 1'b0);
    base = n_starts; d0 = n_done;
    run_frame(0, 1'b0, cyc, sel_d, busy_d);
    check("t3_latency",  cyc, 27);
    check("t3_te_rise",  te_rise - log_cyc[base], 17);
    check("t3_te_after", timeout_err, 1'b1);
    check("t3_ndone",    n_done - d0, 1);
    misroute[0] = 1'b0;

    // Erase latched at frame_start; second frame_start mid-sweep (with erase_in=0) ignored.
    d0 = n_done;
    run_frame(4, 1'b1, cyc, sel_d, busy_d);
    check("t4_latency", cyc, 16);
    repeat (3) @(negedge clk);
    check("t4_erase_held",   erase,       1'b1);
    check("t4_busy_idle",    busy,        1'b0);
    check("t4_ndone",        n_done - d0, 1);
    check("t4_te_sticky",    timeout_err, 1'b1);

    // All counts zero; frame_start during DONE ignored.
    entity_table = '0;
    class_count = '0;
    base = n_starts; d0 = n_done;
    run_frame(8, 1'b0, cyc, sel_d, busy_d);
    check("t5_latency", cyc, 8);
    repeat (2) @(negedge clk);
    check("t5_busy_idle", busy,            1'b0);
    check("t5_nstarts",   n_starts - base, 0);
    check("t5_ndone",     n_done - d0,     1);
    check("t5_erase",     erase,           1'b0);

    // Reset while waiting on a drawer.
    entity_table = '0;
    set_ent(0, 0, 1'b1);
    class_count = {3'd0, 3'd0, 3'd1};
    misroute[0] = 1'b1;
    erase_in = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0;
    while (draw_start == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t6_start_seen", draw_start, 3'b001);
    repeat (3) @(negedge clk);
    check("t6_busy_wait", busy, 1'b1);
    reset_n = 1'b0;
    d0 = n_done;
    @(negedge clk);
    check("t6_busy",       busy,        1'b0);
    check("t6_class_sel",  class_sel,   3'b000);
    check("t6_timeout",    timeout_err, 1'b0);
    check("t6_frame_done", frame_done,  1'b0);
    check("t6_erase",      erase,       1'b0);
    reset_n = 1'b1;
    misroute[0] = 1'b0;
    repeat (25) @(negedge clk);
    check("t6_no_done",   n_done - d0, 0);
    check("t6_stay_idle", busy,        1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
Per-frame scheduler that walks a parametrised set of entity classes (ship, asteroids, shots, ...) and hands each valid entity to its class's sprite drawer via a start/done handshake. It sits between game-state registers and the sprite drawers, and feeds the VGA pixel mux select. It generalises the fixed three-class walker with:
- N classes and a runtime per-class count
- skipping of invalid slots
- frame trigger and busy/done status
- erase mode
- per-drawer timeout with sticky error

Parameters:
ENTITY_SIZE, 34, bits per entity record
NUM_CLASSES, 3, number of entity classes; class 0 is drawn first
SLOTS, 16, maximum slots per class
VALID_BIT, 33, bit index of the entity plot/valid flag
TIMEOUT, 4096, max cycles to wait for draw_done before abort

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
frame_start  in  1  pulse; begin a sweep (ignored while busy)
erase_in  in  1  sampled with frame_start; 1 = erase sweep
class_count  in  NUM_CLASSES*$clog2(SLOTS+1)  active slots per class, packed, class 0 in LSBs
entity_table  in  NUM_CLASSES*SLOTS*ENTITY_SIZE  flat entity array; slot s of class c at index c*SLOTS+s
draw_done  in  NUM_CLASSES  per-drawer completion pulse
entity  out  ENTITY_SIZE  latched record for the current draw
class_sel  out  NUM_CLASSES  one-hot drawer select for the pixel mux; 0 when idle
draw_start  out  NUM_CLASSES  one-cycle start pulse to the selected drawer
erase  out  1  latched erase_in for the current sweep
busy  out  1  high from first FETCH through DONE
frame_done  out  1  one-cycle pulse at end of sweep
timeout_err  out  1  sticky; set on any drawer timeout

Behaviour:
Reset (reset_n=0 at posedge):
- state IDLE; all outputs 0; counters 0; timeout_err cleared.
- Reset mid-sweep aborts immediately; no frame_done is issued.

States:
- IDLE: on frame_start=1, latch erase_in -> erase and clear cls/slot counters -> FETCH. With no frame_start, stay in IDLE.
- FETCH (1 cycle):
  - If slot >= class_count[cls] (clamped to SLOTS) -> NEXT_CLASS.
  - Else if entity_table[cls][slot][VALID_BIT]=0 -> NEXT_SLOT (skip; nothing is drawn).
  - Else latch the record into entity, set class_sel=1<<cls -> START.
- START (1 cycle): draw_start[cls]=1; clear the wait counter -> WAIT.
- WAIT:
  - draw_done[cls]=1 -> NEXT_SLOT.
  - Wait counter reaches TIMEOUT-1 -> set timeout_err -> NEXT_SLOT.
  - draw_done bits of non-selected classes are ignored.
- NEXT_SLOT: slot++.
  - If slot was SLOTS-1 -> NEXT_CLASS.
  - Else -> FETCH.
- NEXT_CLASS: slot=0, cls++.
  - If cls was NUM_CLASSES-1 -> DONE.
  - Else -> FETCH.
- DONE: frame_done=1 for one cycle; class_sel=0 -> IDLE.

Timing and handshake:
- busy=1 in every state except IDLE.
- Sweep latency = 2 + sum over classes of (class overhead) + per-slot cost:
  - skipped or empty slot: 2 cycles
  - drawn entity: 4 cycles + drawer time
- entity and class_sel stay constant from FETCH-exit until the next FETCH, so drawers may sample them at any time during WAIT.
- draw_done asserted in the same cycle as draw_start is not honoured. Drawers respond no earlier than the cycle after START.

Boundary conditions:
- class_count=0 for a class: that class is skipped in 1 FETCH + 1 NEXT_CLASS.
- class_count>SLOTS is treated as SLOTS.
- All counts 0: frame_done arrives NUM_CLASSES*2+2 cycles after frame_start.
- frame_start while busy is ignored, not queued.
- frame_start in the same cycle as frame_done's DONE state is ignored (DONE is not IDLE).
- entity_table changes during the sweep affect only slots not yet fetched.

Decomposition:
Shared package draw_pkg holds:
- the state enum
- ENTITY_SIZE, VALID_BIT
- entity field slices (x, y, dir, sprite_sel, valid) as localparams, for drawers to share.

Sub-module slot_walker holds the cls/slot counters, count clamp and end detection. The FSM and handshake live in draw_scheduler.

Test Plan:
- Counts {1,3,0}, all valid; drawers ack 5 cycles after start -> start order c0s0, c1s0, c1s1, c1s2; 4 draw_start pulses; frame_done once; busy falls the cycle after DONE.
- Class 1 count 4 with slots 1 and 3 invalid -> draw_start only for slots 0 and 2; skipped slots take 2 cycles each.
- Drawer for c0 never acks, TIMEOUT=16 -> WAIT lasts exactly 16 cycles; timeout_err=1 and stays 1; sweep continues and frame_done still asserts.
- frame_start with erase_in=1, then erase_in=0 mid-sweep -> erase stays 1 until the next sweep; second frame_start pulse while busy is ignored.
- All counts 0 with NUM_CLASSES=3 -> frame_done 8 cycles after frame_start; draw_start never asserts.
- reset_n=0 during WAIT -> next cycle: IDLE, class_sel=0, busy=0, timeout_err=0, no frame_done.
